// File: rtl/moore_fsm_pkg.sv
// Shared defaults and overlap-mode constants for the Moore sequence detector.
package moore_fsm_pkg;

  localparam int         DEF_N   = 4;
  localparam logic [3:0] DEF_PAT = 4'b1011;
  localparam int         DEF_CW  = 8;

  localparam bit OVERLAP_OFF = 1'b0;
  localparam bit OVERLAP_ON  = 1'b1;

endpackage : moore_fsm_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky flag that is raised when the maximum is reached.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          sat
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          sat_reg;
  logic          sat_next;

  always_comb begin
    cnt_next = cnt_reg;
    sat_next = sat_reg;
    if (clr) begin
      cnt_next = '0;
      sat_next = 1'b0;
    end else if (inc && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
      // Flag goes up on the same edge the count reaches its ceiling.
      if (cnt_reg == CNT_MAX - 1'b1) begin
        sat_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      sat_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      sat_reg <= sat_next;
    end
  end

  assign cnt = cnt_reg;
  assign sat = sat_reg;

endmodule : sat_counter

// File: rtl/moore_seq_detector.sv
// Programmable Moore sequence detector: shift history, fill tracking, registered match
// output and a saturating match counter.
module moore_seq_detector
  import moore_fsm_pkg::*;
#(
  parameter int           N       = DEF_N,
  parameter logic [N-1:0] PAT_RST = N'(DEF_PAT),
  parameter bit           OVERLAP = OVERLAP_ON,
  parameter int           CW      = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          x,
  input  logic          en,
  input  logic          load,
  input  logic [N-1:0]  pattern_in,
  output logic          y,
  output logic [CW-1:0] match_cnt,
  output logic          cnt_sat
);

  localparam int             FW        = $clog2(N + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(N);

  logic [N-1:0]  hist_reg;
  logic [N-1:0]  hist_next;
  logic [N-1:0]  hist_shift;
  logic [N-1:0]  pat_reg;
  logic [FW-1:0] fill_reg;
  logic [FW-1:0] fill_next;
  logic          y_reg;
  logic          y_next;
  logic          cnt_inc;

  // New bit enters at the LSB so the oldest bit sits at the MSB, matching pattern order.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign hist_shift[gi] = x;
      end else begin : g_upper
        assign hist_shift[gi] = hist_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    hist_next = hist_reg;
    fill_next = fill_reg;
    if (load) begin
      hist_next = '0;
      fill_next = '0;
    end else if (en) begin
      hist_next = hist_shift;
      if ((OVERLAP == OVERLAP_OFF) && y_reg) begin
        fill_next = FW'(1);
      end else if (fill_reg != FILL_FULL) begin
        fill_next = fill_reg + 1'b1;
      end
    end
  end

  // Registering the decode of next state gives y exactly the decode of current state.
  assign y_next  = (fill_next == FILL_FULL) && (hist_next == pat_reg);
  assign cnt_inc = !load && en && y_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_reg <= '0;
      fill_reg <= '0;
      pat_reg  <= PAT_RST;
      y_reg    <= 1'b0;
    end else begin
      hist_reg <= hist_next;
      fill_reg <= fill_next;
      y_reg    <= y_next;
      if (load) begin
        pat_reg <= pattern_in;
      end
    end
  end

  sat_counter #(
    .CW (CW)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .inc (cnt_inc),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

  assign y = y_reg;

endmodule : moore_seq_detector

// File: tb/tb_moore_seq_detector.sv
// Directed bench: overlap, non-overlap and CW=2 instances share one stimulus stream.
module tb_moore_seq_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       x;
  logic       en;
  logic       load;
  logic [3:0] pattern_in;

  logic       y_ov, y_no, y_s;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_s;
  logic       sat_ov, sat_no, sat_s;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  moore_seq_detector #(.N(4), .PAT_RST(4'b1011), .OVERLAP(1'b1), .CW(8)) dut_ov (
    .clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pattern_in(pattern_in),
    .y(y_ov), .match_cnt(cnt_ov), .cnt_sat(sat_ov)
  );

  moore_seq_detector #(.N(4), .PAT_RST(4'b1011), .OVERLAP(1'b0), .CW(8)) dut_no (
    .clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pattern_in(pattern_in),
    .y(y_no), .match_cnt(cnt_no), .cnt_sat(sat_no)
  );

  moore_seq_detector #(.N(4), .PAT_RST(4'b1011), .OVERLAP(1'b1), .CW(2)) dut_sat (
    .clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pattern_in(pattern_in),
    .y(y_s), .match_cnt(cnt_s), .cnt_sat(sat_s)
  );

  task automatic send_bit(input logic b);
    x  = b;
    en = 1'b1;
    @(posedge clk);
    #1;
    $display("bit x=%0b en=1 | ov y=%0b cnt=%0d | no y=%0b cnt=%0d | cw2 cnt=%0d sat=%0b",
             b, y_ov, cnt_ov, y_no, cnt_no, cnt_s, sat_s);
  endtask

  task automatic idle_bit(input logic b);
    x  = b;
    en = 1'b0;
    @(posedge clk);
    #1;
    $display("bit x=%0b en=0 | ov y=%0b cnt=%0d", b, y_ov, cnt_ov);
  endtask

  task automatic do_reset();
    rst = 1'b1; x = 1'b0; en = 1'b0; load = 1'b0; pattern_in = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; x = 1'b0; en = 1'b0; load = 1'b0; pattern_in = 4'b0000;
    #2;
    total_cnt++;
    if (y_ov !== 1'b0) $display("FAIL reset_y: got %0b expected 0", y_ov); else pass_cnt++;
    total_cnt++;
    if (cnt_ov !== 8'd0) $display("FAIL reset_cnt: got %0d expected 0", cnt_ov); else pass_cnt++;
    total_cnt++;
    if (sat_ov !== 1'b0) $display("FAIL reset_sat: got %0b expected 0", sat_ov); else pass_cnt++;
    total_cnt++;
    if (y_s !== 1'b0 || cnt_s !== 2'd0) $display("FAIL reset_cw2: got y=%0b cnt=%0d expected 0/0", y_s, cnt_s); else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    logic [6:0] exp_y;
    bits  = 7'b1011011;
    exp_y = 7'b0001001;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      send_bit(bits[i]);
      total_cnt++;
      if (y_ov !== exp_y[i]) $display("FAIL overlap_y bit%0d: got %0b expected %0b", 7 - i, y_ov, exp_y[i]); else pass_cnt++;
    end
    total_cnt++;
    if (cnt_ov !== 8'd2) $display("FAIL overlap_cnt: got %0d expected 2", cnt_ov); else pass_cnt++;
    total_cnt++;
    if (sat_ov !== 1'b0) $display("FAIL overlap_sat: got %0b expected 0", sat_ov); else pass_cnt++;
  endtask

  task automatic test_non_overlap();
    logic [6:0] bits;
    logic [6:0] exp_y;
    bits  = 7'b1011011;
    exp_y = 7'b0001000;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      send_bit(bits[i]);
      total_cnt++;
      if (y_no !== exp_y[i]) $display("FAIL nonoverlap_y bit%0d: got %0b expected %0b", 7 - i, y_no, exp_y[i]); else pass_cnt++;
    end
    total_cnt++;
    if (cnt_no !== 8'd1) $display("FAIL nonoverlap_cnt: got %0d expected 1", cnt_no); else pass_cnt++;
  endtask

  task automatic test_enable();
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    idle_bit(1'b1);
    total_cnt++;
    if (y_ov !== 1'b0) $display("FAIL enable_hold0_a: got %0b expected 0", y_ov); else pass_cnt++;
    idle_bit(1'b0);
    total_cnt++;
    if (y_ov !== 1'b0) $display("FAIL enable_hold0_b: got %0b expected 0", y_ov); else pass_cnt++;
    send_bit(1'b1);
    total_cnt++;
    if (y_ov !== 1'b1) $display("FAIL enable_match_y: got %0b expected 1", y_ov); else pass_cnt++;
    total_cnt++;
    if (cnt_ov !== 8'd1) $display("FAIL enable_match_cnt: got %0d expected 1", cnt_ov); else pass_cnt++;
    idle_bit(1'b0);
    idle_bit(1'b1);
    total_cnt++;
    if (y_ov !== 1'b1) $display("FAIL enable_hold1_y: got %0b expected 1", y_ov); else pass_cnt++;
    total_cnt++;
    if (cnt_ov !== 8'd1) $display("FAIL enable_hold1_cnt: got %0d expected 1", cnt_ov); else pass_cnt++;
    send_bit(1'b0);
    total_cnt++;
    if (y_ov !== 1'b0) $display("FAIL enable_release_y: got %0b expected 0", y_ov); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (y_ov !== 1'b0) $display("FAIL rstmid_async_y: got %0b expected 0", y_ov); else pass_cnt++;
    total_cnt++;
    if (cnt_ov !== 8'd0) $display("FAIL rstmid_async_cnt: got %0d expected 0", cnt_ov); else pass_cnt++;
    #2;
    rst = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    send_bit(1'b1);
    total_cnt++;
    if (y_ov !== 1'b0) $display("FAIL rstmid_partial_y: got %0b expected 0", y_ov); else pass_cnt++;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    total_cnt++;
    if (y_ov !== 1'b1) $display("FAIL rstmid_full_y: got %0b expected 1", y_ov); else pass_cnt++;
    total_cnt++;
    if (cnt_ov !== 8'd1) $display("FAIL rstmid_full_cnt: got %0d expected 1", cnt_ov); else pass_cnt++;
  endtask

  task automatic test_load();
    logic [5:0] exp_y;
    exp_y = 6'b000111;
    load = 1'b1; pattern_in = 4'b1111; x = 1'b1; en = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    $display("load pattern=1111 | ov y=%0b cnt=%0d sat=%0b", y_ov, cnt_ov, sat_ov);
    total_cnt++;
    if (cnt_ov !== 8'd0 || y_ov !== 1'b0) $display("FAIL load_clear: got y=%0b cnt=%0d expected 0/0", y_ov, cnt_ov); else pass_cnt++;
    for (int i = 5; i >= 0; i--) begin
      send_bit(1'b1);
      total_cnt++;
      if (y_ov !== exp_y[i]) $display("FAIL load_y bit%0d: got %0b expected %0b", 6 - i, y_ov, exp_y[i]); else pass_cnt++;
    end
    total_cnt++;
    if (cnt_ov !== 8'd3) $display("FAIL load_cnt: got %0d expected 3", cnt_ov); else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [4];
    logic       exp_sat [4];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
    exp_sat = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int m = 0; m < 4; m++) begin
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      total_cnt++;
      if (cnt_s !== exp_cnt[m]) $display("FAIL sat_cnt match%0d: got %0d expected %0d", m + 1, cnt_s, exp_cnt[m]); else pass_cnt++;
      total_cnt++;
      if (sat_s !== exp_sat[m]) $display("FAIL sat_flag match%0d: got %0b expected %0b", m + 1, sat_s, exp_sat[m]); else pass_cnt++;
      send_bit(1'b0);
    end
    total_cnt++;
    if (cnt_ov !== 8'd4 || sat_ov !== 1'b0) $display("FAIL sat_wide: got cnt=%0d sat=%0b expected 4/0", cnt_ov, sat_ov); else pass_cnt++;
    load = 1'b1; pattern_in = 4'b1011; en = 1'b0;
    @(posedge clk);
    #1;
    load = 1'b0;
    $display("load pattern=1011 | cw2 cnt=%0d sat=%0b", cnt_s, sat_s);
    total_cnt++;
    if (cnt_s !== 2'd0) $display("FAIL sat_load_cnt: got %0d expected 0", cnt_s); else pass_cnt++;
    total_cnt++;
    if (sat_s !== 1'b0) $display("FAIL sat_load_flag: got %0b expected 0", sat_s); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_enable();
    test_reset_mid();
    test_load();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_moore_seq_detector
